// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit driving the datapath strobes.
// Optional single-step mode: define SEQ_STEP_EN to add the `step` input.
module control_sequencer #(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             clr,
`ifdef SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic [31:0]      ir,
  input  logic             mem_rdy,
  output logic             PC_out,
  output logic             Zlo_out,
  output logic             Zhi_out,
  output logic             MDR_out,
  output logic             MAR_rd,
  output logic             PC_rd,
  output logic             MDR_rd,
  output logic             IR_rd,
  output logic             Y_rd,
  output logic             Zlo_rd,
  output logic             Zhi_rd,
  output logic             LO_rd,
  output logic             HI_rd,
  output logic             IncPC,
  output logic             Read,
  output logic [4:0]       op_sel,
  output logic [NREGS-1:0] R_rd,
  output logic [NREGS-1:0] R_wrt,
  output logic             run,
  output logic             ill_op
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8
  } state_t;

  state_t state_q, state_d;
  logic   t0_go_s;

  logic [4:0] opcode_s;
  logic [3:0] ra_s, rb_s, rc_s;
  logic       is_alu_s, is_muldiv_s, is_nop_s, is_halt_s;
  logic       unused_s;

  assign opcode_s    = ir[31:27];
  assign ra_s        = ir[26:23];
  assign rb_s        = ir[22:19];
  assign rc_s        = ir[18:15];
  assign unused_s    = ^ir[14:0];
  assign is_alu_s    = (opcode_s <= 5'h0E);
  assign is_muldiv_s = (opcode_s == 5'h0F) || (opcode_s == 5'h10);
  assign is_nop_s    = (opcode_s == 5'h1B);
  assign is_halt_s   = (opcode_s == 5'h1C);

  // Indices at or beyond NREGS select no register.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [3:0] idx);
    logic [NREGS-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (i == int'(idx)) v[i] = 1'b1;
      else                v[i] = 1'b0;
    end
    return v;
  endfunction

`ifdef SEQ_STEP_EN
  logic armed_q, armed_d;

  // Step-arm flag: set when step is sampled while waiting in T0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) armed_q <= 1'b0;
    else      armed_q <= armed_d;
  end

  assign t0_go_s = armed_q;
`else
  assign t0_go_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
`ifdef SEQ_STEP_EN
    armed_d = armed_q;
`endif
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        if (t0_go_s) begin
          state_d = S_T1;
`ifdef SEQ_STEP_EN
          armed_d = 1'b0;
`endif
        end else begin
          state_d = S_T0;
`ifdef SEQ_STEP_EN
          armed_d = step;
`endif
        end
      end
      S_T1: begin
        if (mem_rdy) state_d = S_T2;
        else         state_d = S_T1;
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_alu_s || is_muldiv_s) state_d = S_T4;
        else if (is_halt_s)          state_d = S_HALT;
        else                         state_d = S_T0;
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_muldiv_s) state_d = S_T6;
        else             state_d = S_T0;
      end
      S_T6:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Strobe decode from state and instruction fields.
  always_comb begin
    PC_out  = 1'b0;
    Zlo_out = 1'b0;
    Zhi_out = 1'b0;
    MDR_out = 1'b0;
    MAR_rd  = 1'b0;
    PC_rd   = 1'b0;
    MDR_rd  = 1'b0;
    IR_rd   = 1'b0;
    Y_rd    = 1'b0;
    Zlo_rd  = 1'b0;
    Zhi_rd  = 1'b0;
    LO_rd   = 1'b0;
    HI_rd   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    op_sel  = 5'h00;
    R_rd    = '0;
    R_wrt   = '0;
    ill_op  = 1'b0;
    run     = (state_q != S_HALT);
    case (state_q)
      S_T0: begin
        if (t0_go_s) begin
          PC_out = 1'b1;
          MAR_rd = 1'b1;
          IncPC  = 1'b1;
          Zlo_rd = 1'b1;
        end else begin
          PC_out = 1'b0;
        end
      end
      S_T1: begin
        Zlo_out = 1'b1;
        Read    = 1'b1;
        MDR_rd  = 1'b1;
        PC_rd   = mem_rdy;
      end
      S_T2: begin
        MDR_out = 1'b1;
        IR_rd   = 1'b1;
      end
      S_T3: begin
        if (is_alu_s || is_muldiv_s) begin
          R_wrt = reg_onehot(rb_s);
          Y_rd  = 1'b1;
        end else begin
          ill_op = !(is_nop_s || is_halt_s);
        end
      end
      S_T4: begin
        R_wrt  = reg_onehot(rc_s);
        op_sel = opcode_s;
        Zlo_rd = 1'b1;
        Zhi_rd = is_muldiv_s;
      end
      S_T5: begin
        Zlo_out = 1'b1;
        if (is_muldiv_s) LO_rd = 1'b1;
        else             R_rd  = reg_onehot(ra_s);
      end
      S_T6: begin
        Zhi_out = 1'b1;
        HI_rd   = 1'b1;
      end
      default: begin
        PC_out = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: expected per-cycle strobe
// traces are built from the instruction-class timing rules.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [31:0] ir;
  logic        mem_rdy;
  logic        step;
  logic        PC_out, Zlo_out, Zhi_out, MDR_out;
  logic        MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, LO_rd, HI_rd;
  logic        IncPC, Read, run, ill_op;
  logic [4:0]  op_sel;
  logic [15:0] R_rd, R_wrt;

  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, mdr_out;
    logic mar_rd, pc_rd, mdr_rd, ir_rd, y_rd, zlo_rd, zhi_rd, lo_rd, hi_rd;
    logic inc_pc, read, run, ill_op;
    logic [4:0]  op_sel;
    logic [15:0] r_rd;
    logic [15:0] r_wrt;
  } ctl_t;

  ctl_t obs;
  assign obs = {PC_out, Zlo_out, Zhi_out, MDR_out, MAR_rd, PC_rd, MDR_rd, IR_rd,
                Y_rd, Zlo_rd, Zhi_rd, LO_rd, HI_rd, IncPC, Read, run, ill_op,
                op_sel, R_rd, R_wrt};

  int n_checks = 0;
  int n_fail   = 0;

  ctl_t exp_q[$];
  logic rdy_q[$];
  logic stp_q[$];

  control_sequencer #(.NREGS(16)) dut (
    .clk(clk), .clr(clr),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .ir(ir), .mem_rdy(mem_rdy),
    .PC_out(PC_out), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out), .MDR_out(MDR_out),
    .MAR_rd(MAR_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd),
    .Zlo_rd(Zlo_rd), .Zhi_rd(Zhi_rd), .LO_rd(LO_rd), .HI_rd(HI_rd),
    .IncPC(IncPC), .Read(Read), .op_sel(op_sel), .R_rd(R_rd), .R_wrt(R_wrt),
    .run(run), .ill_op(ill_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  task automatic push(input ctl_t c, input logic r, input logic s);
    exp_q.push_back(c);
    rdy_q.push_back(r);
    stp_q.push_back(s);
  endtask

  // Expected trace of one instruction starting in T0 with `waits` memory stalls.
  task automatic build(input logic [31:0] instr, input int waits);
    ctl_t c;
    logic [4:0] op;
    int ra, rb, rc;
    op = instr[31:27];
    ra = int'(instr[26:23]);
    rb = int'(instr[22:19]);
    rc = int'(instr[18:15]);
    exp_q.delete(); rdy_q.delete(); stp_q.delete();
`ifdef SEQ_STEP_EN
    push(idle(), 1'($urandom_range(0, 1)), 1'b1);
`endif
    c = idle(); c.pc_out = 1'b1; c.mar_rd = 1'b1; c.inc_pc = 1'b1; c.zlo_rd = 1'b1;
    push(c, 1'($urandom_range(0, 1)), 1'b0);
    c = idle(); c.zlo_out = 1'b1; c.read = 1'b1; c.mdr_rd = 1'b1;
    for (int w = 0; w < waits; w++) push(c, 1'b0, 1'b0);
    c.pc_rd = 1'b1;
    push(c, 1'b1, 1'b0);
    c = idle(); c.mdr_out = 1'b1; c.ir_rd = 1'b1;
    push(c, 1'($urandom_range(0, 1)), 1'b0);
    if (op <= 5'h10) begin
      c = idle(); c.r_wrt = 16'h0001 << rb; c.y_rd = 1'b1;
      push(c, 1'($urandom_range(0, 1)), 1'b0);
      c = idle(); c.r_wrt = 16'h0001 << rc; c.op_sel = op; c.zlo_rd = 1'b1;
      c.zhi_rd = (op >= 5'h0F);
      push(c, 1'($urandom_range(0, 1)), 1'b0);
      if (op < 5'h0F) begin
        c = idle(); c.zlo_out = 1'b1; c.r_rd = 16'h0001 << ra;
        push(c, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        c = idle(); c.zlo_out = 1'b1; c.lo_rd = 1'b1;
        push(c, 1'($urandom_range(0, 1)), 1'b0);
        c = idle(); c.zhi_out = 1'b1; c.hi_rd = 1'b1;
        push(c, 1'($urandom_range(0, 1)), 1'b0);
      end
    end else begin
      c = idle(); c.ill_op = (op != 5'h1B) && (op != 5'h1C);
      push(c, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic rdy, input logic stp);
    @(negedge clk);
    ir      = instr;
    mem_rdy = rdy;
    step    = stp;
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; ir = 32'h0; mem_rdy = 1'b0; step = 1'b0;
    #3 clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(32'h0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== idle()) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %h want %h", i, obs, idle());
      end
    end
    clr = 1'b1;
    build(32'h521B8000, 0);
    for (int i = 0; i < 5; i++) begin
      drive(32'h521B8000, rdy_q[i], stp_q[i]);
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_pre cyc %0d: got %h want %h", i, obs, exp_q[i]);
      end
    end
    #2 clr = 1'b0;
    #1;
    n_checks++;
    if (obs !== idle()) begin
      n_fail++;
      $display("FAIL reset_async_T4: got %h want %h", obs, idle());
    end
    drive(32'h521B8000, 1'b1, 1'b0);
    n_checks++;
    if (obs !== idle()) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", obs, idle());
    end
    clr = 1'b1;
  endtask

  task automatic test_alu();
    for (int k = 0; k < 2; k++) begin
      build(32'h521B8000, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        drive(32'h521B8000, rdy_q[i], stp_q[i]);
        n_checks++;
        if (obs !== exp_q[i]) begin
          n_fail++;
          $display("FAIL alu_shra pass %0d cyc %0d: got %h want %h", k, i, obs, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_fetch_wait();
    build(32'h10918000, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive(32'h10918000, rdy_q[i], stp_q[i]);
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fetch_wait cyc %0d: got %h want %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [31:0] instrs [2];
    instrs[0] = 32'h78128000;
    instrs[1] = 32'h8123C000;
    for (int k = 0; k < 2; k++) begin
      build(instrs[k], k);
      for (int i = 0; i < exp_q.size(); i++) begin
        drive(instrs[k], rdy_q[i], stp_q[i]);
        n_checks++;
        if (obs !== exp_q[i]) begin
          n_fail++;
          $display("FAIL muldiv %h cyc %0d: got %h want %h", instrs[k], i, obs, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_illegal_nop();
    logic [31:0] instrs [2];
    instrs[0] = 32'hF8000000;
    instrs[1] = 32'hD8000000;
    for (int k = 0; k < 2; k++) begin
      build(instrs[k], 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        drive(instrs[k], rdy_q[i], stp_q[i]);
        n_checks++;
        if (obs !== exp_q[i]) begin
          n_fail++;
          $display("FAIL illegal_nop %h cyc %0d: got %h want %h", instrs[k], i, obs, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] instr;
    logic [4:0]  op;
    int sel;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      op = 5'($urandom_range(0, 14));
      else if (sel <= 7) op = 5'($urandom_range(15, 16));
      else if (sel == 8) op = 5'h1B;
      else begin
        op = 5'($urandom_range(17, 31));
        if (op == 5'h1B || op == 5'h1C) op = 5'h1F;
      end
      instr = {op, 27'($urandom)};
      build(instr, $urandom_range(0, 3));
      for (int i = 0; i < exp_q.size(); i++) begin
        drive(instr, rdy_q[i], stp_q[i]);
        n_checks++;
        if (obs !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random %h cyc %0d: got %h want %h", instr, i, obs, exp_q[i]);
        end
      end
    end
  endtask

`ifdef SEQ_STEP_EN
  task automatic test_step();
    for (int i = 0; i < 10; i++) begin
      drive(32'h521B8000, 1'($urandom_range(0, 1)), 1'b0);
      n_checks++;
      if (obs !== idle()) begin
        n_fail++;
        $display("FAIL step_wait cyc %0d: got %h want %h", i, obs, idle());
      end
    end
    build(32'h521B8000, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive(32'h521B8000, rdy_q[i], stp_q[i]);
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL step_one cyc %0d: got %h want %h", i, obs, exp_q[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(32'h521B8000, 1'b1, 1'b0);
      n_checks++;
      if (obs !== idle()) begin
        n_fail++;
        $display("FAIL step_after cyc %0d: got %h want %h", i, obs, idle());
      end
    end
  endtask
`endif

  task automatic test_halt();
    ctl_t halted;
    halted = '0;
    build(32'hE0000000, 1);
    for (int i = 0; i < 20; i++) push(halted, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < exp_q.size(); i++) begin
      drive(32'hE0000000, rdy_q[i], stp_q[i]);
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL halt cyc %0d: got %h want %h", i, obs, exp_q[i]);
      end
    end
    #2 clr = 1'b0;
    #1;
    n_checks++;
    if (obs !== idle()) begin
      n_fail++;
      $display("FAIL halt_reset: got %h want %h", obs, idle());
    end
    drive(32'h0, 1'b1, 1'b0);
    clr = 1'b1;
    build(32'h00918000, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      drive(32'h00918000, rdy_q[i], stp_q[i]);
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL after_halt cyc %0d: got %h want %h", i, obs, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fetch_wait();
    test_muldiv();
    test_illegal_nop();
    test_random();
`ifdef SEQ_STEP_EN
    test_step();
`endif
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
